aes_round_seq: RTL
==================

# aes_round_seq

Iterative AES-128 encryption controller that sequences a single `aesround` datapath instance through rounds 1–10.
- Accepts a plaintext block and cipher key over a valid/ready handshake.
- Performs the initial AddRoundKey itself, then generates each round key on the fly, one round per clock.
- Presents the ciphertext over a valid/ready output handshake.
- Sits between the block-level request interface and the `aesround` datapath.

## Interface
- `BACK2BACK`, default 0: when 1, `in_ready` is also high in DONE while `out_ready` is high, so a new block is accepted in the drain cycle.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: request carries a valid block and key.
- `in_ready` out 1: controller can accept.
- `in_data` in 128: plaintext; byte i = bits [8i+7:8i], FIPS state byte i, column-major.
- `in_key` in 128: cipher key, same byte order.
- `out_valid` out 1: ciphertext valid.
- `out_ready` in 1: consumer accepts.
- `out_data` out 128: ciphertext, same byte order.
- `busy` out 1: high in BUSY state.
- `abort` in 1: synchronous discard of the block in flight.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0.
- Reset values of internal registers: `state_q`=0, `key_q`=0, `cnt_q`=0.
- IDLE, on `in_valid && in_ready`:
  - `state_q <= in_data ^ in_key` (round-0 AddRoundKey).
  - `key_q <= in_key`.
  - `cnt_q <= 11'b000_0000_0010`.
  - Next state BUSY.
- `cnt_q` is one-hot. Bit r marks round r, r = 1..10.
  - It drives `fin_counter_in`.
  - `fin_counter_out` (shift left by 1) loads back into `cnt_q` each BUSY cycle.
- BUSY, each cycle:
  - `aesround.round_in = state_q`; `round_key = kx_next`.
  - `kx_next` = key-schedule step of `key_q` with rcon(r).
  - `state_q <= round_out`, `key_q <= kx_next`.
- MixColumns bypass in round 10 comes from `cnt_q[10]`, which the controller sets to 1 in that round.
- Leaving BUSY: when `cnt_q[10]`=1 the round-10 update is taken and the next state is DONE.
- rcon for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Selected by the one-hot index of `cnt_q`.
- Key step (word j = bytes 4j..4j+3):
  - t = SubWord(RotWord(w3)) with rcon XORed into t byte 0.
  - RotWord maps (b12, b13, b14, b15) to (b13, b14, b15, b12).
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- DONE: `out_valid`=1 and `out_data = state_q`, held stable until `out_valid && out_ready`. Then the next state is IDLE.
- Drain cycle with `BACK2BACK`=1 and `in_valid`: load as in IDLE and go directly to BUSY.
- `abort`:
  - In any state: next state IDLE, `cnt_q <= 0`, no output produced. `out_data` keeps its value but `out_valid` drops.
  - `abort` wins over a simultaneous accept or drain.
- `in_ready`:
  - Low in BUSY.
  - Low in DONE unless `BACK2BACK`=1 and `out_ready`=1.
  - Combinational from state and `out_ready` only; never from `in_valid`.
- `rst_n` asserted mid-operation returns to IDLE immediately. The block in flight is lost.
- `cnt_q` not one-hot in BUSY is unreachable; covered by an assertion.

## Timing
- Accept edge E0. Rounds 1..10 update on edges E1..E10.
- `out_valid` is high from the cycle after E10: latency 10 cycles from accept to `out_valid`.
- Minimum block period:
  - 12 cycles with `BACK2BACK`=0 (accept, 10 rounds, drain, IDLE).
  - 11 cycles with `BACK2BACK`=1.
- `out_data` and `out_valid` are registered. No combinational path from `in_*` to `out_*`.
- Critical path: `state_q` → SBOX → ShiftRows → MixColumns → XOR → `state_q`, in parallel with `key_q` → SBOX → XOR chain → `key_q`.

## Structure
- Package `aes_pkg` holds:
  - the `SBOX` constant (256×8), shared with `aesround`;
  - the `RCON` table (10×8);
  - the state enum typedef {IDLE, BUSY, DONE};
  - the `aes_block_t` typedef, logic [15:0][7:0].
- Sub-module `aes_key_step`: combinational, inputs `key_in` [127:0] and `rcon` [7:0], output `key_out` [127:0].
- `aesround` is instantiated once inside `aes_round_seq`.

## Test plan
- FIPS-197 C.1, key 000102..0f, plaintext 00112233..ff:
  - Stimulus: `in_key`=128'h0f0e0d0c0b0a09080706050403020100, `in_data`=128'hffeeddccbbaa99887766554433221100.
  - Required: `out_data`=128'h5ac5b47080b7cdd830047b6ad8e0c469, with `out_valid` rising exactly 10 cycles after accept.
- FIPS-197 Appendix B:
  - Stimulus: `in_key`=128'h3c4fcf098815f7aba6d2ae2816157e2b, `in_data`=128'h340737e0a29831318d305a88a8f64332.
  - Required: `out_data`=128'h320b6a19978511dcfb09dc021d842539.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid`.
  - Required: `out_data` stable and `in_ready`=0 throughout; one transfer on release; `in_ready`=1 the following cycle.
- `BACK2BACK`=1: offer the C.1 block then the B block with `out_ready`=1 held.
  - Required: the second accept occurs in the drain cycle of the first; outputs appear in order, 11 cycles apart.
- `abort` asserted in round 5:
  - Required: IDLE next cycle, `out_valid` never rises.
  - A following C.1 block produces the correct ciphertext.
- `rst_n` pulsed low in round 7:
  - Required: `in_ready`=1, `out_valid`=0, `busy`=0 immediately, without waiting for a clock edge.
  - A subsequent C.1 block produces the correct ciphertext.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the iterative round controller and its datapath.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} aes_fsm_e;

  typedef logic [15:0][7:0] aes_block_t;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: derives round key r+1 from round key r and rcon(r+1).
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] t, w0, w1, w2, w3;

  // SubWord(RotWord(w3)): byte 0 of t comes from key byte 13, byte 3 from key byte 12.
  assign t = {SBOX[key_in[103:96]], SBOX[key_in[127:120]], SBOX[key_in[119:112]],
              SBOX[key_in[111:104]] ^ rcon};

  assign w0 = key_in[31:0] ^ t;
  assign w1 = key_in[63:32] ^ w0;
  assign w2 = key_in[95:64] ^ w1;
  assign w3 = key_in[127:96] ^ w2;

  assign key_out = {w3, w2, w1, w0};

endmodule

// File: rtl/aesround.sv
// Single AES encryption round; MixColumns is bypassed when the round counter marks round 10.
module aesround
  import aes_pkg::*;
(
  input  logic [127:0] round_in,
  input  logic [127:0] round_key,
  input  logic [10:0]  fin_counter_in,
  output logic [127:0] round_out,
  output logic [10:0]  fin_counter_out
);

  aes_block_t s_in, sb, sr, mc;

  always_comb begin
    s_in = round_in;
    sb   = '0;
    sr   = '0;
    mc   = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = SBOX[s_in[i]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  assign round_out       = (fin_counter_in[10] ? sr : mc) ^ round_key;
  assign fin_counter_out = {fin_counter_in[9:0], 1'b0};

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES-128 encryption controller: one round per clock through a single aesround
// instance, with the key schedule expanded on the fly alongside the data.
module aes_round_seq
  import aes_pkg::*;
#(
  parameter bit BACK2BACK = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  input  logic         abort
);

  aes_fsm_e     fsm_q, fsm_d;
  logic [127:0] state_q, state_d, key_q, key_d, kx_next, round_out;
  logic [10:0]  cnt_q, cnt_d, cnt_next;
  logic [7:0]   rcon;
  logic         accept;

  // One-hot counter to rcon: AND-OR select, no priority needed.
  always_comb begin
    rcon = '0;
    for (int r = 1; r <= 10; r++) begin
      if (cnt_q[r]) rcon |= RCON[r-1];
    end
  end

  aes_key_step u_key_step (
    .key_in  (key_q),
    .rcon    (rcon),
    .key_out (kx_next)
  );

  aesround u_round (
    .round_in        (state_q),
    .round_key       (kx_next),
    .fin_counter_in  (cnt_q),
    .round_out       (round_out),
    .fin_counter_out (cnt_next)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    unique case (fsm_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = in_data ^ in_key;
          key_d   = in_key;
          cnt_d   = 11'b000_0000_0010;
          fsm_d   = BUSY;
        end else if (fsm_q == DONE && out_ready) begin
          fsm_d = IDLE;
        end
      end
      BUSY: begin
        state_d = round_out;
        key_d   = kx_next;
        cnt_d   = cnt_next;
        if (cnt_q[10]) fsm_d = DONE;
      end
      default: fsm_d = IDLE;
    endcase
    // Abort overrides any load or round update; out_data keeps the old value.
    if (abort) begin
      fsm_d   = IDLE;
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = '0;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    unique case (fsm_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = BACK2BACK && out_ready;
      default: in_ready = 1'b0;
    endcase
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == BUSY);
    out_data  = state_q;
  end

  cnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    (fsm_q == BUSY) |-> $onehot(cnt_q));

endmodule
